// File: rtl/writeback_regfile.sv
// Writeback register file with same-cycle write bypass and a
// per-register pending-write scoreboard that drives decode stall.
module writeback_regfile #(
    parameter  int DATA_W    = 16,
    parameter  int REG_COUNT = 16,
    parameter  int PS_W      = 4,
    parameter  int PEND_W    = 2,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    input  logic              wb_reg_write,
    input  logic [AW-1:0]     wb_reg_addr,
    input  logic [DATA_W-1:0] wb_reg_data,
    input  logic              wb_ps_write,
    input  logic [PS_W-1:0]   wb_ps_data,
    input  logic [AW-1:0]     rd_addr_a,
    input  logic [AW-1:0]     rd_addr_t,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_t,
    output logic [PS_W-1:0]   ps_out,
    input  logic              iss_valid,
    input  logic              iss_reg_write,
    input  logic [AW-1:0]     iss_dest,
    input  logic              iss_use_t,
    output logic              stall,
    output logic              err_underflow
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [DATA_W-1:0] r_regs [REG_COUNT];
    logic [PEND_W-1:0] r_pend [REG_COUNT];
    logic [PS_W-1:0]   r_ps;
    logic              r_err;

    logic              w_commit;
    logic              w_ps_commit;
    logic              w_accept;
    logic              w_stall;
    logic [PEND_W-1:0] w_eff_a;
    logic [PEND_W-1:0] w_eff_t;
    logic [PEND_W-1:0] w_pend_nxt [REG_COUNT];
    logic              w_inc;
    logic              w_hit;

    assign w_commit    = wb_valid & wb_reg_write & (wb_reg_addr != '0);
    assign w_ps_commit = wb_valid & wb_ps_write;
    assign w_accept    = iss_valid & ~w_stall & iss_reg_write
                       & (iss_dest != '0);

    // Read ports: R0 hardwired to zero, same-cycle commit bypasses the array
    always_comb begin
        rd_data_a = '0;
        rd_data_t = '0;
        if (rd_addr_a != '0) begin
            if (w_commit && (wb_reg_addr == rd_addr_a))
                rd_data_a = wb_reg_data;
            else
                rd_data_a = r_regs[rd_addr_a];
        end
        if (rd_addr_t != '0) begin
            if (w_commit && (wb_reg_addr == rd_addr_t))
                rd_data_t = wb_reg_data;
            else
                rd_data_t = r_regs[rd_addr_t];
        end
    end

    // Effective pending count: a commit this cycle already retires one write
    always_comb begin
        w_eff_a = r_pend[rd_addr_a];
        w_eff_t = r_pend[rd_addr_t];
        if (w_commit && (wb_reg_addr == rd_addr_a) && (w_eff_a != '0))
            w_eff_a = w_eff_a - PEND_ONE;
        if (w_commit && (wb_reg_addr == rd_addr_t) && (w_eff_t != '0))
            w_eff_t = w_eff_t - PEND_ONE;
    end

    // Hazard stall: RAW on either source, or destination counter saturated
    always_comb begin
        w_stall = 1'b0;
        if (w_eff_a != '0)
            w_stall = 1'b1;
        if (iss_use_t && (w_eff_t != '0))
            w_stall = 1'b1;
        if (iss_reg_write && (r_pend[iss_dest] == PEND_MAX))
            w_stall = 1'b1;
    end

    // Next pending counts: issue and commit to one register cancel out
    always_comb begin
        w_inc = 1'b0;
        w_hit = 1'b0;
        for (int i = 0; i < REG_COUNT; i++) begin
            w_pend_nxt[i] = r_pend[i];
            w_inc = w_accept && (iss_dest == AW'(i));
            w_hit = w_commit && (wb_reg_addr == AW'(i));
            if (w_inc && !w_hit)
                w_pend_nxt[i] = r_pend[i] + PEND_ONE;
            else if (w_hit && !w_inc && (r_pend[i] != '0))
                w_pend_nxt[i] = r_pend[i] - PEND_ONE;
        end
    end

    // Architectural state: registers, status, counters, sticky underflow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
                r_pend[i] <= '0;
            end
            r_ps  <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_commit)
                r_regs[wb_reg_addr] <= wb_reg_data;
            if (w_ps_commit)
                r_ps <= wb_ps_data;
            if (w_commit && (r_pend[wb_reg_addr] == '0))
                r_err <= 1'b1;
            for (int i = 0; i < REG_COUNT; i++)
                r_pend[i] <= w_pend_nxt[i];
        end
    end

    assign stall         = w_stall;
    assign ps_out        = r_ps;
    assign err_underflow = r_err;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed self-checking bench for writeback_regfile.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [3:0]  wb_reg_addr;
    logic [15:0] wb_reg_data;
    logic        wb_ps_write;
    logic [3:0]  wb_ps_data;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_t;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_t;
    logic [3:0]  ps_out;
    logic        iss_valid;
    logic        iss_reg_write;
    logic [3:0]  iss_dest;
    logic        iss_use_t;
    logic        stall;
    logic        err_underflow;

    int vectors = 0;
    int miscompares = 0;

    writeback_regfile dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_reg_addr   (wb_reg_addr),
        .wb_reg_data   (wb_reg_data),
        .wb_ps_write   (wb_ps_write),
        .wb_ps_data    (wb_ps_data),
        .rd_addr_a     (rd_addr_a),
        .rd_addr_t     (rd_addr_t),
        .rd_data_a     (rd_data_a),
        .rd_data_t     (rd_data_t),
        .ps_out        (ps_out),
        .iss_valid     (iss_valid),
        .iss_reg_write (iss_reg_write),
        .iss_dest      (iss_dest),
        .iss_use_t     (iss_use_t),
        .stall         (stall),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        wb_valid      = 1'b0;
        wb_reg_write  = 1'b0;
        wb_reg_addr   = '0;
        wb_reg_data   = '0;
        wb_ps_write   = 1'b0;
        wb_ps_data    = '0;
        iss_valid     = 1'b0;
        iss_reg_write = 1'b0;
        iss_dest      = '0;
        iss_use_t     = 1'b0;
    endtask

    task automatic commit(input logic [3:0] a, input logic [15:0] d);
        wb_valid     = 1'b1;
        wb_reg_write = 1'b1;
        wb_reg_addr  = a;
        wb_reg_data  = d;
    endtask

    task automatic issue(input logic [3:0] d);
        iss_valid     = 1'b1;
        iss_reg_write = 1'b1;
        iss_dest      = d;
    endtask

    initial begin
        clr();
        rd_addr_a = '0;
        rd_addr_t = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        rd_addr_a = 4'd3;
        rd_addr_t = 4'd7;
        #1;
        chk("rst_rd_a", rd_data_a, 16'h0);
        chk("rst_rd_t", rd_data_t, 16'h0);
        chk("rst_ps", ps_out, 4'h0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_err", err_underflow, 1'b0);

        // issue R5, then commit R5 with bypass and a PS write
        tick();
        rd_addr_a = 4'd0;
        rd_addr_t = 4'd0;
        issue(4'd5);
        #1;
        chk("iss5_stall", stall, 1'b0);
        tick();
        clr();
        rd_addr_a = 4'd5;
        #1;
        chk("pend5_stall", stall, 1'b1);
        commit(4'd5, 16'hBEEF);
        wb_ps_write = 1'b1;
        wb_ps_data  = 4'hA;
        #1;
        chk("byp_rd_a", rd_data_a, 16'hBEEF);
        chk("byp_release", stall, 1'b0);
        chk("ps_no_byp", ps_out, 4'h0);
        tick();
        clr();
        #1;
        chk("reg_rd_a", rd_data_a, 16'hBEEF);
        chk("ps_upd", ps_out, 4'hA);
        chk("no_uflow5", err_underflow, 1'b0);

        // R0 write ignored
        rd_addr_a = 4'd0;
        commit(4'd0, 16'h1234);
        #1;
        chk("r0_byp", rd_data_a, 16'h0);
        tick();
        clr();
        #1;
        chk("r0_after", rd_data_a, 16'h0);
        chk("r0_no_uflow", err_underflow, 1'b0);

        // RAW stall on R2, released by same-cycle commit
        issue(4'd2);
        #1;
        chk("iss2_stall", stall, 1'b0);
        tick();
        clr();
        rd_addr_a = 4'd2;
        #1;
        chk("raw_stall", stall, 1'b1);
        commit(4'd2, 16'h5A5A);
        #1;
        chk("raw_release", stall, 1'b0);
        chk("raw_data", rd_data_a, 16'h5A5A);
        tick();
        clr();
        #1;
        chk("raw_after_st", stall, 1'b0);
        chk("raw_after_d", rd_data_a, 16'h5A5A);

        // immediate operand: rt pending ignored unless used
        rd_addr_a = 4'd0;
        issue(4'd4);
        tick();
        clr();
        rd_addr_a = 4'd5;
        rd_addr_t = 4'd4;
        #1;
        chk("imm_nostall", stall, 1'b0);
        chk("imm_rd_t", rd_data_t, 16'h0);
        iss_use_t = 1'b1;
        #1;
        chk("use_t_stall", stall, 1'b1);
        iss_use_t = 1'b0;

        // saturation on R6
        rd_addr_a = 4'd0;
        rd_addr_t = 4'd0;
        for (int k = 0; k < 3; k++) begin
            issue(4'd6);
            #1;
            chk("sat_fill", stall, 1'b0);
            tick();
        end
        issue(4'd6);
        #1;
        chk("sat_stall", stall, 1'b1);
        tick();
        clr();
        commit(4'd6, 16'h0101);
        tick();
        clr();
        issue(4'd6);
        commit(4'd6, 16'h0606);
        #1;
        chk("conc_accept", stall, 1'b0);
        tick();
        clr();
        issue(4'd6);
        #1;
        chk("conc_pend2", stall, 1'b0);
        tick();
        clr();
        issue(4'd6);
        #1;
        chk("conc_pend3", stall, 1'b1);
        tick();
        clr();
        rd_addr_a = 4'd6;
        commit(4'd6, 16'h0A0A);
        #1;
        chk("drain3", stall, 1'b1);
        tick();
        commit(4'd6, 16'h0B0B);
        #1;
        chk("drain2", stall, 1'b1);
        tick();
        commit(4'd6, 16'h0C0C);
        #1;
        chk("drain1", stall, 1'b0);
        tick();
        clr();
        #1;
        chk("drain_st", stall, 1'b0);
        chk("drain_d", rd_data_a, 16'h0C0C);
        chk("drain_err", err_underflow, 1'b0);

        // underflow on R9
        rd_addr_a = 4'd9;
        rd_addr_t = 4'd9;
        commit(4'd9, 16'h9999);
        #1;
        chk("uf_byp_a", rd_data_a, 16'h9999);
        chk("uf_byp_t", rd_data_t, 16'h9999);
        chk("uf_stall", stall, 1'b0);
        chk("uf_err_pre", err_underflow, 1'b0);
        tick();
        clr();
        #1;
        chk("uf_data", rd_data_a, 16'h9999);
        chk("uf_err", err_underflow, 1'b1);
        tick();
        chk("uf_sticky", err_underflow, 1'b1);

        // reset overrides a concurrent commit and issue
        rst_n = 1'b0;
        commit(4'd9, 16'h1111);
        issue(4'd2);
        tick();
        rst_n = 1'b1;
        clr();
        rd_addr_a = 4'd9;
        rd_addr_t = 4'd5;
        #1;
        chk("rst2_err", err_underflow, 1'b0);
        chk("rst2_ps", ps_out, 4'h0);
        chk("rst2_rd_a", rd_data_a, 16'h0);
        chk("rst2_rd_t", rd_data_t, 16'h0);
        rd_addr_a = 4'd4;
        rd_addr_t = 4'd2;
        iss_use_t = 1'b1;
        #1;
        chk("rst2_stall", stall, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
